dac_handler: RTL and testbench

Serialises 12-bit samples into 16-bit frames for the board's SPI-style serial DAC (DAC121S101-class: SYNC, SCLK, DIN). It is the output stage that consumes samples produced by the ADC capture and filter path and drives the top-level `DAC_OUT` pin. It runs on the same sample clock that is forwarded to the converters. A one-entry pending buffer absorbs a sample that arrives while a frame is in flight.

---
 rtl/dac_handler.sv | 177 +++++++++++++++++
 tb/tb_dac_handler.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_handler.sv
`default_nettype none
// ============================================================================
// Module      : dac_handler
// Description : Serialises 12-bit samples into 16-bit frames for an SPI-style
//               serial DAC (SYNC / SCLK / DIN). The frame layout, MSB first,
//               is {2'b00, PD_MODE, sample}. A one-entry pending buffer
//               absorbs a sample that arrives while a frame is in flight.
//               The newest sample always wins. Overwriting a buffered sample
//               sets the sticky overrun flag.
// Ports       : d_clk       - sample clock; all logic runs on its rising edge
//               not_rst     - synchronous, active-low reset
//               dac_data    - unsigned sample, taken when data_valid = 1
//               data_valid  - single-cycle "new sample" strobe
//               clr_overrun - synchronous clear of overrun; a set wins
//               d_in        - serial data to DAC DIN, MSB first
//               not_sync    - frame strobe, low for FRAME_W cycles per frame
//               busy        - high while a frame or its gap is in progress
//               overrun     - sticky, a pending sample was overwritten
// Revision    : 1.0 - initial release
// ============================================================================
module dac_handler #(
    parameter int         DATA_W   = 12,
    parameter int         FRAME_W  = 16,
    parameter logic [1:0] PD_MODE  = 2'b00,
    parameter int         SYNC_GAP = 1
) (
    input  logic              d_clk,
    input  logic              not_rst,
    input  logic [DATA_W-1:0] dac_data,
    input  logic              data_valid,
    input  logic              clr_overrun,
    output logic              d_in,
    output logic              not_sync,
    output logic              busy,
    output logic              overrun
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_CNT_W = $clog2(FRAME_W);
    localparam int c_GAP_W = (SYNC_GAP > 1) ? $clog2(SYNC_GAP) : 1;
    localparam int c_PAD_W = FRAME_W - DATA_W - 2;

    localparam logic [c_CNT_W-1:0] c_BIT_FIRST = c_CNT_W'(FRAME_W - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_FIRST = c_GAP_W'(SYNC_GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic [FRAME_W-1:0]  r_shift;
    logic [c_CNT_W-1:0]  r_bit_cnt;
    logic [c_GAP_W-1:0]  r_gap_cnt;
    logic                r_pend_valid;
    logic [DATA_W-1:0]   r_pend_data;
    logic                r_overrun;
    logic                r_d_in;
    logic                r_not_sync;
    logic                r_busy;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [FRAME_W-1:0]  w_frame_new;
    logic [FRAME_W-1:0]  w_frame_pend;
    logic                w_gap_last;
    logic                w_pend_write;
    logic                w_ovr_set;

    assign w_frame_new  = {{c_PAD_W{1'b0}}, PD_MODE, dac_data};
    assign w_frame_pend = {{c_PAD_W{1'b0}}, PD_MODE, r_pend_data};
    assign w_gap_last   = (r_state == ST_GAP) && (r_gap_cnt == '0);

    // A strobe during a frame lands in the pending buffer, except on the last
    // gap cycle, where it is loaded straight into the shift register instead.
    assign w_pend_write = data_valid &&
                          ((r_state == ST_SHIFT) ||
                           ((r_state == ST_GAP) && !w_gap_last));
    assign w_ovr_set    = w_pend_write && r_pend_valid;

    // ------------------------------------------------------------------------
    // FSM, datapath and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge d_clk) begin
        if (!not_rst) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_pend_valid <= 1'b0;
            r_pend_data  <= '0;
            r_overrun    <= 1'b0;
            r_d_in       <= 1'b0;
            r_not_sync   <= 1'b1;
            r_busy       <= 1'b0;
        end else begin
            // The outputs are a registered view of the current state. This
            // keeps DIN stable from one rising edge to the next, so the DAC
            // can sample it on the falling edge.
            r_d_in     <= (r_state == ST_SHIFT) ? r_shift[FRAME_W-1] : 1'b0;
            r_not_sync <= (r_state != ST_SHIFT);
            r_busy     <= (r_state != ST_IDLE);

            // Sticky overrun. A set in the same cycle as a clear wins.
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun) begin
                r_overrun <= 1'b0;
            end

            // Pending buffer. It is emptied on the last gap cycle, whether it
            // was consumed or was superseded by a newer strobe.
            if (w_pend_write) begin
                r_pend_valid <= 1'b1;
                r_pend_data  <= dac_data;
            end else if (w_gap_last) begin
                r_pend_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (data_valid) begin
                        r_shift   <= w_frame_new;
                        r_bit_cnt <= c_BIT_FIRST;
                        r_state   <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
                    if (r_bit_cnt == '0) begin
                        r_gap_cnt <= c_GAP_FIRST;
                        r_state   <= ST_GAP;
                    end else begin
                        r_bit_cnt <= r_bit_cnt - 1'b1;
                    end
                end

                ST_GAP: begin
                    if (r_gap_cnt == '0) begin
                        if (data_valid) begin
                            r_shift   <= w_frame_new;
                            r_bit_cnt <= c_BIT_FIRST;
                            r_state   <= ST_SHIFT;
                        end else if (r_pend_valid) begin
                            r_shift   <= w_frame_pend;
                            r_bit_cnt <= c_BIT_FIRST;
                            r_state   <= ST_SHIFT;
                        end else begin
                            r_state   <= ST_IDLE;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign d_in     = r_d_in;
    assign not_sync = r_not_sync;
    assign busy     = r_busy;
    assign overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_dac_handler.sv
`default_nettype none
// ============================================================================
// Module      : tb_dac_handler
// Description : Self-checking bench for dac_handler. Three instances share
//               one stimulus stream: the default configuration, one with
//               PD_MODE = 2'b11 and one with SYNC_GAP = 3. A frame-schedule
//               reference model predicts the outputs of each instance every
//               cycle. Each scenario task also checks the captured frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_handler;

    logic        clk = 1'b0;
    logic        not_rst;
    logic        data_valid;
    logic        clr_overrun;
    logic [11:0] dac_data;

    wire  [2:0]  d_in_v;
    wire  [2:0]  not_sync_v;
    wire  [2:0]  busy_v;
    wire  [2:0]  ov_v;

    always #5 clk = ~clk;

    dac_handler u_dut (
        .d_clk(clk), .not_rst(not_rst), .dac_data(dac_data),
        .data_valid(data_valid), .clr_overrun(clr_overrun),
        .d_in(d_in_v[0]), .not_sync(not_sync_v[0]),
        .busy(busy_v[0]), .overrun(ov_v[0])
    );

    dac_handler #(.PD_MODE(2'b11)) u_pd (
        .d_clk(clk), .not_rst(not_rst), .dac_data(dac_data),
        .data_valid(data_valid), .clr_overrun(clr_overrun),
        .d_in(d_in_v[1]), .not_sync(not_sync_v[1]),
        .busy(busy_v[1]), .overrun(ov_v[1])
    );

    dac_handler #(.SYNC_GAP(3)) u_gap3 (
        .d_clk(clk), .not_rst(not_rst), .dac_data(dac_data),
        .data_valid(data_valid), .clr_overrun(clr_overrun),
        .d_in(d_in_v[2]), .not_sync(not_sync_v[2]),
        .busy(busy_v[2]), .overrun(ov_v[2])
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model state, one entry per instance. m_pos counts the cycles since
    // the current frame was loaded. Positions 0..15 are the bits, and the
    // next SYNC_GAP positions are the gap.
    int          m_gap   [3];
    logic [1:0]  m_pdm   [3];
    bit          m_active[3];
    int          m_pos   [3];
    logic [15:0] m_frame [3];
    bit          m_pv    [3];
    logic [11:0] m_pdata [3];
    bit          m_ov    [3];

    // Frame capture from the serial pins
    int          cap_len   [3];
    logic [15:0] cap_bits  [3];
    int          hi_len    [3];
    logic [15:0] last_frame[3];
    logic [15:0] prev_frame[3];
    int          last_len  [3];
    int          last_gap  [3];
    int          frames    [3];

    function automatic logic [15:0] mk_frame(input int i, input logic [11:0] d);
        return {2'b00, m_pdm[i], d};
    endfunction

    task automatic model_step(input int i, input bit dv, input logic [11:0] d,
                              input bit clr, input bit rst_n);
        bit set_ov;
        set_ov = 1'b0;
        if (!rst_n) begin
            m_active[i] = 1'b0; m_pos[i] = 0; m_pv[i] = 1'b0; m_ov[i] = 1'b0;
            return;
        end
        if (!m_active[i]) begin
            if (dv) begin
                m_active[i] = 1'b1; m_pos[i] = 0; m_frame[i] = mk_frame(i, d);
            end
        end else if (m_pos[i] == 15 + m_gap[i]) begin
            // End of the gap. The newest sample wins, and pending is discarded.
            if (dv) begin
                m_pos[i] = 0; m_frame[i] = mk_frame(i, d);
            end else if (m_pv[i]) begin
                m_pos[i] = 0; m_frame[i] = mk_frame(i, m_pdata[i]);
            end else begin
                m_active[i] = 1'b0;
            end
            m_pv[i] = 1'b0;
        end else begin
            m_pos[i]++;
            if (dv) begin
                if (m_pv[i]) set_ov = 1'b1;
                m_pv[i] = 1'b1; m_pdata[i] = d;
            end
        end
        if (set_ov) m_ov[i] = 1'b1;
        else if (clr) m_ov[i] = 1'b0;
    endtask

    // Drive one cycle, then check every instance against the model.
    task automatic tick(input bit dv, input logic [11:0] d, input bit clr, input bit rst_n);
        bit e_ns, e_din, e_busy;
        not_rst = rst_n; data_valid = dv; dac_data = d; clr_overrun = clr;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            // The pins show the model state as it was before this edge.
            if (!rst_n) begin
                e_ns = 1'b1; e_din = 1'b0; e_busy = 1'b0;
            end else if (m_active[i] && m_pos[i] < 16) begin
                e_ns = 1'b0; e_din = m_frame[i][15 - m_pos[i]]; e_busy = 1'b1;
            end else begin
                e_ns = 1'b1; e_din = 1'b0; e_busy = m_active[i];
            end
            model_step(i, dv, d, clr, rst_n);
            checks += 4;
            if (not_sync_v[i] !== e_ns) begin
                failures++;
                $display("FAIL not_sync inst=%0d cyc=%0d got=%b exp=%b", i, cyc, not_sync_v[i], e_ns);
            end
            if (d_in_v[i] !== e_din) begin
                failures++;
                $display("FAIL d_in inst=%0d cyc=%0d got=%b exp=%b", i, cyc, d_in_v[i], e_din);
            end
            if (busy_v[i] !== e_busy) begin
                failures++;
                $display("FAIL busy inst=%0d cyc=%0d got=%b exp=%b", i, cyc, busy_v[i], e_busy);
            end
            if (ov_v[i] !== m_ov[i]) begin
                failures++;
                $display("FAIL overrun inst=%0d cyc=%0d got=%b exp=%b", i, cyc, ov_v[i], m_ov[i]);
            end
            // Capture frames from the pins
            if (not_sync_v[i] === 1'b0) begin
                if (cap_len[i] == 0) last_gap[i] = hi_len[i];
                cap_bits[i] = {cap_bits[i][14:0], d_in_v[i]};
                cap_len[i]++;
                hi_len[i] = 0;
            end else begin
                if (cap_len[i] > 0) begin
                    prev_frame[i] = last_frame[i];
                    last_frame[i] = cap_bits[i];
                    last_len[i]   = cap_len[i];
                    frames[i]++;
                    cap_len[i]    = 0;
                end
                hi_len[i]++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 12'h000, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) tick(1'b1, 12'hFFF, 1'b0, 1'b0);
        checks++;
        if ({not_sync_v, d_in_v, busy_v, ov_v} !== {3'b111, 3'b000, 3'b000, 3'b000}) begin
            failures++;
            $display("FAIL reset_state got ns=%b din=%b busy=%b ov=%b exp ns=111 others=000",
                     not_sync_v, d_in_v, busy_v, ov_v);
        end
        idle(3);
    endtask

    task automatic test_single_frame();
        int f0;
        f0 = frames[0];
        tick(1'b1, 12'hABC, 1'b0, 1'b1);
        idle(20);
        checks += 4;
        if (frames[0] !== f0 + 1 || last_len[0] !== 16) begin
            failures++;
            $display("FAIL single_count got frames=%0d len=%0d exp frames=%0d len=16", frames[0] - f0, last_len[0], 1);
        end
        if (last_frame[0] !== 16'h0ABC) begin
            failures++;
            $display("FAIL single_frame got=%h exp=0abc", last_frame[0]);
        end
        if (last_frame[1] !== 16'h3ABC) begin
            failures++;
            $display("FAIL single_frame_pd got=%h exp=3abc", last_frame[1]);
        end
        if (busy_v !== 3'b000) begin
            failures++;
            $display("FAIL single_busy_end got=%b exp=000", busy_v);
        end
    endtask

    task automatic test_pd_mode();
        tick(1'b1, 12'h000, 1'b0, 1'b1);
        idle(22);
        checks++;
        if (last_frame[1] !== 16'h3000) begin
            failures++;
            $display("FAIL pd_zero got=%h exp=3000", last_frame[1]);
        end
        tick(1'b1, 12'hFFF, 1'b0, 1'b1);
        idle(22);
        checks += 2;
        if (last_frame[1] !== 16'h3FFF) begin
            failures++;
            $display("FAIL pd_full got=%h exp=3fff", last_frame[1]);
        end
        if (last_frame[0] !== 16'h0FFF) begin
            failures++;
            $display("FAIL pd_normal got=%h exp=0fff", last_frame[0]);
        end
    endtask

    task automatic test_pending();
        tick(1'b1, 12'h123, 1'b0, 1'b1);
        idle(4);
        tick(1'b1, 12'h456, 1'b0, 1'b1);
        idle(45);
        checks += 3;
        if (prev_frame[0] !== 16'h0123 || last_frame[0] !== 16'h0456) begin
            failures++;
            $display("FAIL pending_frames got=%h,%h exp=0123,0456", prev_frame[0], last_frame[0]);
        end
        if (last_gap[0] !== 1 || last_gap[2] !== 3) begin
            failures++;
            $display("FAIL pending_gap got=%0d,%0d exp=1,3", last_gap[0], last_gap[2]);
        end
        if (ov_v !== 3'b000) begin
            failures++;
            $display("FAIL pending_overrun got=%b exp=000", ov_v);
        end
    endtask

    task automatic test_overrun();
        tick(1'b1, 12'h0AA, 1'b0, 1'b1);
        idle(2); tick(1'b1, 12'h111, 1'b0, 1'b1);
        idle(2); tick(1'b1, 12'h222, 1'b0, 1'b1);
        idle(2); tick(1'b1, 12'h333, 1'b0, 1'b1);
        idle(45);
        checks += 2;
        if (prev_frame[0] !== 16'h00AA || last_frame[0] !== 16'h0333) begin
            failures++;
            $display("FAIL overrun_frames got=%h,%h exp=00aa,0333", prev_frame[0], last_frame[0]);
        end
        if (ov_v !== 3'b111) begin
            failures++;
            $display("FAIL overrun_set got=%b exp=111", ov_v);
        end
        tick(1'b0, 12'h000, 1'b1, 1'b1);
        checks++;
        if (ov_v !== 3'b000) begin
            failures++;
            $display("FAIL overrun_clear got=%b exp=000", ov_v);
        end
        tick(1'b1, 12'h555, 1'b0, 1'b1);
        idle(2); tick(1'b1, 12'h666, 1'b0, 1'b1);
        idle(2); tick(1'b1, 12'h777, 1'b1, 1'b1);
        checks++;
        if (ov_v !== 3'b111) begin
            failures++;
            $display("FAIL overrun_set_wins got=%b exp=111", ov_v);
        end
        idle(45);
        tick(1'b0, 12'h000, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        int f0;
        tick(1'b1, 12'h9A5, 1'b0, 1'b1);
        idle(3);
        tick(1'b1, 12'h321, 1'b0, 1'b1);
        idle(3);
        tick(1'b1, 12'h777, 1'b0, 1'b0);
        checks++;
        if (not_sync_v !== 3'b111 || d_in_v !== 3'b000 || busy_v !== 3'b000) begin
            failures++;
            $display("FAIL rst_mid got ns=%b din=%b busy=%b exp 111/000/000", not_sync_v, d_in_v, busy_v);
        end
        f0 = frames[0];
        idle(40);
        checks++;
        if (frames[0] !== f0 || busy_v !== 3'b000) begin
            failures++;
            $display("FAIL rst_pending_lost got new_frames=%0d busy=%b exp 0/000", frames[0] - f0, busy_v);
        end
        tick(1'b1, 12'h5A5, 1'b0, 1'b1);
        idle(22);
        checks++;
        if (last_frame[0] !== 16'h05A5 || last_len[0] !== 16) begin
            failures++;
            $display("FAIL rst_clean_frame got=%h len=%0d exp=05a5 len=16", last_frame[0], last_len[0]);
        end
    endtask

    task automatic test_sync_gap3();
        int f0;
        logic [11:0] d;
        f0 = frames[2];
        d  = 12'h000;
        for (int k = 0; k < 6; k++) begin
            d = 12'($urandom);
            tick(1'b1, d, 1'b0, 1'b1);
            idle(18);
        end
        idle(25);
        checks += 3;
        if (frames[2] !== f0 + 6 || last_frame[2] !== {4'h0, d}) begin
            failures++;
            $display("FAIL gap3_frames got n=%0d last=%h exp n=6 last=%h", frames[2] - f0, last_frame[2], {4'h0, d});
        end
        if (prev_frame[2][15:12] !== 4'h0 || last_gap[2] !== 3) begin
            failures++;
            $display("FAIL gap3_gap got=%0d exp=3", last_gap[2]);
        end
        if (ov_v !== 3'b000) begin
            failures++;
            $display("FAIL gap3_overrun got=%b exp=000", ov_v);
        end
    endtask

    task automatic test_random();
        bit dv, clr, rn;
        int dens;
        for (int k = 0; k < 4000; k++) begin
            dens = (k < 2000) ? 12 : 4;
            dv   = ($urandom_range(dens - 1) == 0);
            clr  = ($urandom_range(15) == 0);
            rn   = ($urandom_range(499) != 0);
            tick(dv, 12'($urandom), clr, rn);
        end
        idle(30);
    endtask

    initial begin
        m_gap = '{1, 1, 3};
        m_pdm = '{2'b00, 2'b11, 2'b00};
        for (int i = 0; i < 3; i++) begin
            m_active[i] = 1'b0; m_pos[i] = 0; m_frame[i] = '0;
            m_pv[i] = 1'b0; m_pdata[i] = '0; m_ov[i] = 1'b0;
            cap_len[i] = 0; cap_bits[i] = '0; hi_len[i] = 0;
            last_frame[i] = '0; prev_frame[i] = '0;
            last_len[i] = 0; last_gap[i] = 0; frames[i] = 0;
        end
        not_rst = 1'b0; data_valid = 1'b0; clr_overrun = 1'b0; dac_data = '0;

        test_reset();
        test_single_frame();
        test_pd_mode();
        test_pending();
        test_overrun();
        test_reset_mid_frame();
        test_sync_gap3();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
